// File: rtl/su_adder_pkg.sv
// ----------------------------------------------------------------------------
// su_adder_pkg
// Shared definitions for the su_adder scheduler slice.
//   - mode_e     : su_adder datapath mode encodings
//   - state_e    : scheduler FSM states
//   - DEF_*      : default widths / limits used as module parameter defaults
//   - cfg_is_legal() : legality rule for an offered configuration word
// ----------------------------------------------------------------------------
package su_adder_pkg;

    localparam int DEF_TILE_BITWIDTH  = 10;
    localparam int DEF_NUM_BITWIDTH   = 5;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        MODE_REL_MEM = 2'd0,  // rel_mem_accumulator
        MODE_V1      = 2'd1,  // su_adder_v1
        MODE_AMBI    = 2'd2,  // su_adder_for_ambi_irrel
        MODE_ILLEGAL = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_PULSE     = 3'd2,
        ST_WAIT_ADD  = 3'd3,
        ST_CONV_DONE = 3'd4,
        ST_DRAIN     = 3'd5
    } state_e;

    // A word is usable only with a real mode and at least one tile.
    function automatic logic cfg_is_legal(input logic [1:0] mode, input logic tile_is_zero);
        return (mode != MODE_ILLEGAL) && !tile_is_zero;
    endfunction

endpackage

// File: rtl/su_adder_cfg_reg.sv
// ----------------------------------------------------------------------------
// su_adder_cfg_reg
// Per-layer configuration register for the su_adder scheduler.
// Consumes one word per cfg_valid & cfg_ready handshake. Legal words are
// latched; illegal words (mode 3 or zero tiles) are consumed but dropped and
// set the sticky cfg_err flag, which only reset clears.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_cfg_valid       : offered word valid
//   i_cfg_ready       : scheduler can accept a word (IDLE)
//   i_cfg_mode        : offered mode
//   i_cfg_irrel_num   : offered irrelevant-loop count
//   i_cfg_rel_num     : offered relevant-loop count
//   i_cfg_tile_num    : offered tiles per conv
//   o_cfg_fire        : handshake happening this cycle
//   o_mode            : latched mode
//   o_irrel_num       : latched irrelevant-loop count
//   o_rel_num         : latched relevant-loop count
//   o_tile_num        : latched tiles per conv
//   o_cfg_err         : sticky illegal-word flag
// ----------------------------------------------------------------------------
module su_adder_cfg_reg
    import su_adder_pkg::*;
#(
    parameter int TILE_BITWIDTH = DEF_TILE_BITWIDTH,
    parameter int NUM_BITWIDTH  = DEF_NUM_BITWIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_cfg_valid,
    input  logic                     i_cfg_ready,
    input  logic [1:0]               i_cfg_mode,
    input  logic [NUM_BITWIDTH-1:0]  i_cfg_irrel_num,
    input  logic [NUM_BITWIDTH-1:0]  i_cfg_rel_num,
    input  logic [TILE_BITWIDTH-1:0] i_cfg_tile_num,
    output logic                     o_cfg_fire,
    output logic [1:0]               o_mode,
    output logic [NUM_BITWIDTH-1:0]  o_irrel_num,
    output logic [NUM_BITWIDTH-1:0]  o_rel_num,
    output logic [TILE_BITWIDTH-1:0] o_tile_num,
    output logic                     o_cfg_err
);

    logic w_fire;
    logic w_legal;

    logic [1:0]               r_mode;
    logic [NUM_BITWIDTH-1:0]  r_irrel_num;
    logic [NUM_BITWIDTH-1:0]  r_rel_num;
    logic [TILE_BITWIDTH-1:0] r_tile_num;
    logic                     r_cfg_err;

    assign w_fire  = i_cfg_valid && i_cfg_ready;
    assign w_legal = cfg_is_legal(i_cfg_mode, i_cfg_tile_num == '0);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= MODE_REL_MEM;
            r_irrel_num <= '0;
            r_rel_num   <= '0;
            // One tile keeps the FSM terminating if start arrives before any
            // legal word was ever latched.
            r_tile_num  <= TILE_BITWIDTH'(1);
            r_cfg_err   <= 1'b0;
        end else if (w_fire) begin
            if (w_legal) begin
                r_mode      <= i_cfg_mode;
                r_irrel_num <= i_cfg_irrel_num;
                r_rel_num   <= i_cfg_rel_num;
                r_tile_num  <= i_cfg_tile_num;
            end else begin
                r_cfg_err   <= 1'b1;
            end
        end
    end

    assign o_cfg_fire  = w_fire;
    assign o_mode      = r_mode;
    assign o_irrel_num = r_irrel_num;
    assign o_rel_num   = r_rel_num;
    assign o_tile_num  = r_tile_num;
    assign o_cfg_err   = r_cfg_err;

endmodule

// File: rtl/su_adder_sched.sv
// ----------------------------------------------------------------------------
// su_adder_sched
// Sequencer for the spatial-unrolling adder between the PE array and
// psum_gbf. Owns per-layer configuration (via su_adder_cfg_reg), turns PE
// "psum ready" events into one-cycle pe_psum_finish pulses, holds the PE
// array while the adder works, and pulses conv_finish after the last tile.
//
// Optional build macro: SU_ADDER_SCHED_TIMEOUT_EN
//   Adds parameter TIMEOUT_CYCLES and output timeout_err. A watchdog runs in
//   WAIT_ADD/DRAIN; expiry sets sticky timeout_err and returns to IDLE
//   without conv_finish. Undefined: waits for su_add_finish indefinitely.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   cfg_valid/ready : config handshake (ready only in IDLE)
//   cfg_mode, cfg_irrel_num, cfg_rel_num, cfg_tile_num : config word
//   start           : begin a conv with the latched config
//   pe_psum_ready   : PE array has a finished psum set
//   pe_hold         : stall PE array
//   pe_psum_finish  : one-cycle pulse to su_adder
//   su_add_finish   : adder done with current set
//   conv_finish     : one-cycle pulse after the last tile
//   mode, irrel_num, rel_num : latched config to su_adder
//   busy            : FSM not in IDLE
//   tile_cnt        : tiles completed in current conv
//   cfg_err         : sticky illegal-config flag
//   timeout_err     : sticky watchdog flag (macro builds only)
// ----------------------------------------------------------------------------
module su_adder_sched
    import su_adder_pkg::*;
#(
    parameter int TILE_BITWIDTH  = DEF_TILE_BITWIDTH,
    parameter int NUM_BITWIDTH   = DEF_NUM_BITWIDTH
`ifdef SU_ADDER_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [1:0]               cfg_mode,
    input  logic [NUM_BITWIDTH-1:0]  cfg_irrel_num,
    input  logic [NUM_BITWIDTH-1:0]  cfg_rel_num,
    input  logic [TILE_BITWIDTH-1:0] cfg_tile_num,
    input  logic                     start,
    input  logic                     pe_psum_ready,
    output logic                     pe_hold,
    output logic                     pe_psum_finish,
    input  logic                     su_add_finish,
    output logic                     conv_finish,
    output logic [1:0]               mode,
    output logic [NUM_BITWIDTH-1:0]  irrel_num,
    output logic [NUM_BITWIDTH-1:0]  rel_num,
    output logic                     busy,
    output logic [TILE_BITWIDTH-1:0] tile_cnt,
    output logic                     cfg_err
`ifdef SU_ADDER_SCHED_TIMEOUT_EN
    , output logic                   timeout_err
`endif
);

    logic                     w_cfg_fire;
    logic                     w_start_req;
    logic [TILE_BITWIDTH-1:0] w_tile_num;
    logic [TILE_BITWIDTH-1:0] w_tile_next;

    state_e                   r_state;
    logic [TILE_BITWIDTH-1:0] r_tile_cnt;
    logic                     r_pe_hold;
    logic                     r_psum_finish;
    logic                     r_conv_finish;
    logic                     r_start_pend;

`ifdef SU_ADDER_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;
    logic            w_to_expired;
    assign w_to_expired = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err  = r_timeout_err;
`endif

    su_adder_cfg_reg #(
        .TILE_BITWIDTH (TILE_BITWIDTH),
        .NUM_BITWIDTH  (NUM_BITWIDTH)
    ) u_cfg_reg (
        .clk             (clk),
        .reset           (reset),
        .i_cfg_valid     (cfg_valid),
        .i_cfg_ready     (cfg_ready),
        .i_cfg_mode      (cfg_mode),
        .i_cfg_irrel_num (cfg_irrel_num),
        .i_cfg_rel_num   (cfg_rel_num),
        .i_cfg_tile_num  (cfg_tile_num),
        .o_cfg_fire      (w_cfg_fire),
        .o_mode          (mode),
        .o_irrel_num     (irrel_num),
        .o_rel_num       (rel_num),
        .o_tile_num      (w_tile_num),
        .o_cfg_err       (cfg_err)
    );

    // Config only moves in IDLE, so mode/irrel/rel are frozen while busy.
    assign cfg_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign w_start_req = start || r_start_pend;
    assign w_tile_next = r_tile_cnt + TILE_BITWIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_tile_cnt    <= '0;
            r_pe_hold     <= 1'b0;
            r_psum_finish <= 1'b0;
            r_conv_finish <= 1'b0;
            r_start_pend  <= 1'b0;
`ifdef SU_ADDER_SCHED_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            // Pulse outputs are high only for the cycle after they are set.
            r_psum_finish <= 1'b0;
            r_conv_finish <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // A config word arriving with start is latched first;
                    // start is remembered and honoured on the next cycle.
                    if (w_start_req && w_cfg_fire) begin
                        r_start_pend <= 1'b1;
                    end else if (w_start_req) begin
                        r_start_pend <= 1'b0;
                        r_tile_cnt   <= '0;
                        r_state      <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (pe_psum_ready) begin
                        r_psum_finish <= 1'b1;
                        r_pe_hold     <= 1'b1;
                        r_state       <= ST_PULSE;
                    end
                end

                ST_PULSE: begin
                    r_state <= ST_WAIT_ADD;
`ifdef SU_ADDER_SCHED_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end

                ST_WAIT_ADD: begin
                    if (su_add_finish) begin
                        r_tile_cnt <= w_tile_next;
                        if (w_tile_next == w_tile_num) begin
                            r_conv_finish <= 1'b1;
                            r_state       <= ST_CONV_DONE;
                        end else begin
                            r_pe_hold <= 1'b0;
                            r_state   <= ST_ARMED;
                        end
`ifdef SU_ADDER_SCHED_TIMEOUT_EN
                    end else if (w_to_expired) begin
                        r_timeout_err <= 1'b1;
                        r_pe_hold     <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
                    end
                end

                ST_CONV_DONE: begin
                    r_state <= ST_DRAIN;
`ifdef SU_ADDER_SCHED_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end

                ST_DRAIN: begin
                    // Final writeback of the last tile still in the adder.
                    if (su_add_finish) begin
                        r_pe_hold <= 1'b0;
                        r_state   <= ST_IDLE;
`ifdef SU_ADDER_SCHED_TIMEOUT_EN
                    end else if (w_to_expired) begin
                        r_timeout_err <= 1'b1;
                        r_pe_hold     <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
                    end
                end

                default: begin
                    r_pe_hold <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign pe_hold        = r_pe_hold;
    assign pe_psum_finish = r_psum_finish;
    assign conv_finish    = r_conv_finish;
    assign tile_cnt       = r_tile_cnt;

endmodule

// File: doc/su_adder_sched.md
Name: su_adder_sched

Overview:
Sequencer and configuration owner for the spatial-unrolling adder (su_adder) between the PE array and psum_gbf. Latches per-layer metadata (mode, irrel_num, rel_num, tile count) through a valid/ready port, replacing file-based init. Converts PE-array "psum ready" events into single-cycle pe_psum_finish pulses, waits for su_add_finish, stalls the PE array while the adder is busy, and issues conv_finish after the last tile.

Parameters:
TILE_BITWIDTH, 10, width of tile counter / cfg_tile_num
NUM_BITWIDTH, 5, width of irrel_num / rel_num
TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with optional feature)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  config word valid
cfg_ready  output  1  high only in IDLE
cfg_mode  input  2  0 rel_mem_accumulator, 1 su_adder_v1, 2 su_adder_for_ambi_irrel, 3 illegal
cfg_irrel_num  input  NUM_BITWIDTH  irrelevant-loop count
cfg_rel_num  input  NUM_BITWIDTH  relevant-loop count
cfg_tile_num  input  TILE_BITWIDTH  tiles per conv, must be >=1
start  input  1  begin conv using latched config
pe_psum_ready  input  1  PE array has a finished psum set
pe_hold  output  1  stall PE array
pe_psum_finish  output  1  one-cycle pulse to su_adder
su_add_finish  input  1  adder done with current set
conv_finish  output  1  one-cycle pulse to su_adder after last tile
mode  output  2  registered mode to su_adder muxes
irrel_num  output  NUM_BITWIDTH  registered
rel_num  output  NUM_BITWIDTH  registered
busy  output  1  state != IDLE
tile_cnt  output  TILE_BITWIDTH  tiles completed in current conv
cfg_err  output  1  sticky: illegal mode or zero tile_num offered

Behaviour:
- Reset (sync, active-high, checked first): state IDLE; mode=0, irrel_num=0, rel_num=0, tile_cnt=0, pe_hold=0, pe_psum_finish=0, conv_finish=0, cfg_err=0, cfg_ready=1 on the following cycle. Reset mid-conv aborts without emitting conv_finish.
- Config: handshake on cfg_valid&cfg_ready. Legal word (mode!=3, tile_num!=0) latched next edge; illegal word is accepted (consumed) but not latched, sets cfg_err. cfg_err cleared only by reset.
- States:
  IDLE: cfg_ready=1. start -> ARMED (tile_cnt<=0). start with cfg handshake in same cycle: config latched first, start honoured one cycle later (start treated as pending).
  ARMED: pe_hold=0. pe_psum_ready -> PULSE.
  PULSE: pe_psum_finish=1 exactly one cycle, pe_hold=1 -> WAIT_ADD.
  WAIT_ADD: pe_hold=1; on su_add_finish: tile_cnt+1; if new count == tile_num -> CONV_DONE else -> ARMED.
  CONV_DONE: conv_finish=1 one cycle, pe_hold=1 -> DRAIN.
  DRAIN: pe_hold=1; waits su_add_finish (final writeback) -> IDLE.
- Latency: pe_psum_ready sampled high -> pe_psum_finish high the next cycle. su_add_finish -> pe_hold low one cycle later (ARMED).
- su_add_finish in ARMED/IDLE ignored. pe_psum_ready in non-ARMED states ignored (PE is held).
- pe_psum_ready and su_add_finish in same WAIT_ADD cycle: finish processed, ready re-sampled in ARMED.
- start outside IDLE ignored. tile_cnt saturates naturally at tile_num; no wrap.
- mode/irrel_num/rel_num constant whenever busy=1.

Optional Feature:
SU_ADDER_SCHED_TIMEOUT_EN: defined -> counter runs in WAIT_ADD/DRAIN, reset on entry; reaching TIMEOUT_CYCLES sets sticky output timeout_err (extra 1-bit port) and forces IDLE with no conv_finish. Undefined -> no counter, no port, waits forever.

Decomposition:
- Shared package su_adder_pkg: mode encodings (MODE_REL_MEM=0, MODE_V1=1, MODE_AMBI=2), state enum, default widths.
- Sub-module su_adder_cfg_reg: config handshake, legality check, cfg_err; FSM stays in su_adder_sched.

Test Plan:
- Config mode=2, irrel=3, rel=4, tiles=2; start; two pe_psum_ready/su_add_finish rounds -> two single-cycle pe_psum_finish, tile_cnt 1 then 2, one conv_finish, DRAIN then IDLE after third su_add_finish.
- Config mode=3 -> cfg_err=1, mode stays previous value (0 after reset); tiles=0 likewise.
- pe_psum_ready held high continuously, tiles=3 -> exactly 3 pe_psum_finish pulses, each separated by su_add_finish, pe_hold high in between.
- Reset asserted in WAIT_ADD with tile_cnt=1 -> next cycle all outputs zero, no conv_finish ever.
- cfg_valid during busy -> cfg_ready=0, config unchanged until IDLE then accepted.
- With SU_ADDER_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, no su_add_finish -> timeout_err=1 after 16 cycles in WAIT_ADD, state IDLE.
